// File: rtl/pipe4_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe4_issue_ctrl_if
// Brief    : Load/control/issue bundle between a controller and the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe4_issue_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int AW    = 4
);
    logic             load_we;
    logic [AW-1:0]    load_addr;
    logic [WIDTH-1:0] load_data;
    logic             start;
    logic             stall;
    logic [WIDTH-1:0] next;
    logic             issue_valid;
    logic [AW-1:0]    pc;
    logic             busy;
    logic             done;

    modport master (
        output load_we, load_addr, load_data, start, stall,
        input  next, issue_valid, pc, busy, done
    );

    modport slave (
        input  load_we, load_addr, load_data, start, stall,
        output next, issue_valid, pc, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/pipe4_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe4_issue_ctrl
// Brief    : Program store + PC sequencer driving the pipeline `next` input.
// Revision : 1.0 - initial release
// ============================================================================
module pipe4_issue_ctrl #(
    parameter int WIDTH = 4,
    parameter int AW    = 4,
    parameter int HOLD  = 1,
    parameter int DEPTH = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pipe4_issue_ctrl_if.slave  bus
);
    localparam int                 c_ENTRIES    = 1 << AW;
    localparam int                 c_DRW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]         c_HOLD_LAST  = 4'(HOLD - 1);
    localparam logic [c_DRW-1:0]   c_DRAIN_INIT = c_DRW'(DEPTH - 1);
    localparam logic [WIDTH-1:0]   c_NOP        = '0;
    localparam logic [WIDTH-1:0]   c_HALT       = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_pc;
    logic [3:0]       r_dwell;
    logic [c_DRW-1:0] r_drain;
    logic [WIDTH-1:0] r_mem [c_ENTRIES];
    logic [WIDTH-1:0] r_next;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_fetch;
    logic             w_loadable;

    assign w_fetch    = r_mem[r_pc];
    assign w_loadable = (r_state == S_IDLE) || (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_dwell <= '0;
            r_drain <= '0;
            r_next  <= c_NOP;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < c_ENTRIES; i++) begin
                r_mem[i] <= c_NOP;
            end
        end else begin
            // The store is only writable while no program is in flight.
            if (w_loadable && bus.load_we) begin
                r_mem[bus.load_addr] <= bus.load_data;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    r_next  <= c_NOP;
                    r_valid <= 1'b0;
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_pc    <= '0;
                        r_dwell <= '0;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                S_RUN: begin
                    if (bus.stall) begin
                        r_next  <= c_NOP;
                        r_valid <= 1'b0;
                    end else if (w_fetch == c_HALT) begin
                        // HALT itself never reaches the pipeline.
                        r_next  <= c_NOP;
                        r_valid <= 1'b0;
                        r_state <= S_DRAIN;
                        r_drain <= c_DRAIN_INIT;
                    end else begin
                        r_next  <= w_fetch;
                        r_valid <= 1'b1;
                        if (r_dwell == c_HOLD_LAST) begin
                            r_dwell <= '0;
                            r_pc    <= r_pc + 1'b1;
                        end else begin
                            r_dwell <= r_dwell + 4'd1;
                        end
                    end
                end

                S_DRAIN: begin
                    r_next  <= c_NOP;
                    r_valid <= 1'b0;
                    if (r_drain == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_next  <= c_NOP;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.next        = r_next;
    assign bus.issue_valid = r_valid;
    assign bus.pc          = r_pc;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
endmodule
`default_nettype wire
